// File: rtl/gb_stencil_conv_if.sv
// Stencil input stream and blurred-pixel output stream of the blur convolution stage.
// The slave side is the convolution block; the master side is its upstream/downstream environment.
interface gb_stencil_conv_if;
    logic [647:0] stencil_TDATA;
    logic         stencil_TVALID;
    logic         stencil_TREADY;
    logic [7:0]   arg_0_TDATA;
    logic         arg_0_TVALID;
    logic         arg_0_TREADY;
    logic         arg_0_TLAST;

    modport slave (
        input  stencil_TDATA, stencil_TVALID, arg_0_TREADY,
        output stencil_TREADY, arg_0_TDATA, arg_0_TVALID, arg_0_TLAST
    );

    modport master (
        output stencil_TDATA, stencil_TVALID, arg_0_TREADY,
        input  stencil_TREADY, arg_0_TDATA, arg_0_TVALID, arg_0_TLAST
    );
endinterface

// File: rtl/gb_stencil_conv.sv
// 9x9 separable binomial blur: one stencil in flight, one kernel row accumulated per cycle,
// rounded 8-bit result presented on an AXI-Stream output with end-of-frame TLAST.
module gb_stencil_conv #(
    parameter int OUT_W = 640,
    parameter int OUT_H = 472
) (
    input  logic             clk,
    input  logic             rst,
    gb_stencil_conv_if.slave io
);
    localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int RW = (OUT_H > 1) ? $clog2(OUT_H) : 1;

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t        state;
    logic [3:0]    row;
    logic [23:0]   acc;
    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;
    logic [647:0]  stencil_reg;

    logic [71:0]   rows [9];
    logic [71:0]   row_word;
    logic [15:0]   term [9];
    logic [15:0]   rs;
    logic [23:0]   acc_next;
    logic [24:0]   rounded;
    logic [7:0]    pix_out;
    logic          frame_last;

    function automatic logic [7:0] kb(input logic [3:0] i);
        case (i)
            4'd0, 4'd8: kb = 8'd1;
            4'd1, 4'd7: kb = 8'd8;
            4'd2, 4'd6: kb = 8'd28;
            4'd3, 4'd5: kb = 8'd56;
            4'd4:       kb = 8'd70;
            default:    kb = 8'd0;
        endcase
    endfunction

    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_rows
            assign rows[gi] = stencil_reg[72*gi +: 72];
        end
    endgenerate

    always_comb begin
        row_word = '0;
        if (row <= 4'd8) row_word = rows[row];
    end

    // Horizontal pass of the current row: 9 weighted pixels, max 255*256 fits 16 bits.
    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_taps
            assign term[gi] = 16'(row_word[8*gi +: 8]) * 16'(kb(4'(gi)));
        end
    endgenerate

    always_comb begin
        rs = '0;
        for (int i = 0; i < 9; i++) rs = rs + term[i];
    end

    assign acc_next   = acc + 24'(kb(row)) * 24'(rs);
    assign rounded    = {1'b0, acc_next} + 25'd32768;
    assign pix_out    = (rounded[24:16] > 9'd255) ? 8'hFF : rounded[23:16];
    assign frame_last = (col_cnt == CW'(OUT_W - 1)) && (row_cnt == RW'(OUT_H - 1));

    // Stencil payload needs no reset; it is only read after a fresh capture.
    always_ff @(posedge clk) begin
        if (state == IDLE && io.stencil_TVALID && io.stencil_TREADY)
            stencil_reg <= io.stencil_TDATA;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            row               <= '0;
            acc               <= '0;
            col_cnt           <= '0;
            row_cnt           <= '0;
            io.stencil_TREADY <= 1'b0;
            io.arg_0_TDATA    <= '0;
            io.arg_0_TVALID   <= 1'b0;
            io.arg_0_TLAST    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (io.stencil_TVALID && io.stencil_TREADY) begin
                        io.stencil_TREADY <= 1'b0;
                        acc               <= '0;
                        row               <= '0;
                        state             <= ACC;
                    end else begin
                        io.stencil_TREADY <= 1'b1;
                    end
                end
                ACC: begin
                    acc <= acc_next;
                    row <= row + 4'd1;
                    if (row == 4'd8) begin
                        io.arg_0_TDATA  <= pix_out;
                        io.arg_0_TVALID <= 1'b1;
                        io.arg_0_TLAST  <= frame_last;
                        state           <= OUT;
                    end
                end
                OUT: begin
                    if (io.arg_0_TREADY) begin
                        io.arg_0_TVALID   <= 1'b0;
                        io.arg_0_TLAST    <= 1'b0;
                        io.stencil_TREADY <= 1'b1;
                        state             <= IDLE;
                        if (col_cnt == CW'(OUT_W - 1)) begin
                            col_cnt <= '0;
                            row_cnt <= (row_cnt == RW'(OUT_H - 1)) ? '0 : row_cnt + 1'b1;
                        end else begin
                            col_cnt <= col_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gb_stencil_conv.sv
// Directed bench for gb_stencil_conv on a 2x2 frame: values, latency, backpressure, TLAST, resets.
module tb_gb_stencil_conv;
    localparam int TW = 2;
    localparam int TH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   out_cnt = 0;
    int   lat;

    gb_stencil_conv_if bus ();

    gb_stencil_conv #(.OUT_W(TW), .OUT_H(TH)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [647:0] fill(input logic [7:0] v);
        return {81{v}};
    endfunction

    function automatic logic [647:0] one_pix(input int r, input int c, input logic [7:0] v);
        logic [647:0] s;
        s = '0;
        s[8*(9*r+c) +: 8] = v;
        return s;
    endfunction

    // Present a stencil, wait for the accept edge; optionally keep TVALID high with new data.
    task automatic send(input logic [647:0] d, input string tag, input bit keep, input logic [647:0] nxt);
        int n;
        n = 0;
        bus.stencil_TDATA  = d;
        bus.stencil_TVALID = 1'b1;
        while (!bus.stencil_TREADY && n < 100) begin
            step();
            n++;
        end
        chk({tag, "_accept_ready"}, 32'(bus.stencil_TREADY), 32'd1);
        step();
        bus.stencil_TDATA = keep ? nxt : fill(8'hA5);
        if (!keep) bus.stencil_TVALID = 1'b0;
    endtask

    task automatic wait_out(output int l);
        l = 0;
        while (!bus.arg_0_TVALID && l < 30) begin
            step();
            l++;
        end
    endtask

    // Full pixel transaction with arg_0_TREADY already high.
    task automatic pixel(input logic [647:0] d, input logic [7:0] exp, input string tag);
        logic exp_last;
        send(d, tag, 1'b0, '0);
        chk({tag, "_tready_low"}, 32'(bus.stencil_TREADY), 32'd0);
        wait_out(lat);
        chk({tag, "_latency"}, 32'(lat), 32'd9);
        exp_last = ((out_cnt % (TW*TH)) == (TW*TH - 1));
        chk({tag, "_data"}, 32'(bus.arg_0_TDATA), 32'(exp));
        chk({tag, "_tlast"}, 32'(bus.arg_0_TLAST), 32'(exp_last));
        step();
        out_cnt++;
        chk({tag, "_valid_drop"}, 32'(bus.arg_0_TVALID), 32'd0);
        chk({tag, "_tready_back"}, 32'(bus.stencil_TREADY), 32'd1);
        $display("txn %s: data=%0d last=%0b latency=%0d", tag, bus.arg_0_TDATA, exp_last, lat);
    endtask

    initial begin
        bus.stencil_TDATA  = '0;
        bus.stencil_TVALID = 1'b0;
        bus.arg_0_TREADY   = 1'b1;
        step();
        step();
        chk("rst_tready", 32'(bus.stencil_TREADY), 32'd0);
        chk("rst_tvalid", 32'(bus.arg_0_TVALID), 32'd0);
        chk("rst_tdata",  32'(bus.arg_0_TDATA), 32'd0);
        chk("rst_tlast",  32'(bus.arg_0_TLAST), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("post_rst_tready", 32'(bus.stencil_TREADY), 32'd1);

        // Outputs 1..5: TLAST expected on output 4 only, then counters wrap.
        pixel(fill(8'd0),   8'd0,   "zero");
        pixel(fill(8'd255), 8'd255, "all255");
        pixel(fill(8'd128), 8'd128, "all128");
        pixel(one_pix(4, 4, 8'd255), 8'd19, "center");
        pixel(one_pix(0, 0, 8'd255), 8'd0,  "corner");

        // Backpressure with a competing stencil held on the input.
        bus.arg_0_TREADY = 1'b0;
        send(fill(8'd128), "bp", 1'b1, fill(8'd255));
        wait_out(lat);
        chk("bp_latency", 32'(lat), 32'd9);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold_data_%0d", i),   32'(bus.arg_0_TDATA), 32'd128);
            chk($sformatf("bp_hold_valid_%0d", i),  32'(bus.arg_0_TVALID), 32'd1);
            chk($sformatf("bp_hold_tready_%0d", i), 32'(bus.stencil_TREADY), 32'd0);
            step();
        end
        bus.arg_0_TREADY = 1'b1;
        step();
        out_cnt++;
        $display("txn bp_held: data=128 released");
        chk("bp_valid_drop", 32'(bus.arg_0_TVALID), 32'd0);
        chk("bp_tready_back", 32'(bus.stencil_TREADY), 32'd1);
        step();
        bus.stencil_TDATA  = '0;
        bus.stencil_TVALID = 1'b0;
        wait_out(lat);
        chk("bp2_latency", 32'(lat), 32'd9);
        chk("bp2_data", 32'(bus.arg_0_TDATA), 32'd255);
        chk("bp2_tlast", 32'(bus.arg_0_TLAST), 32'(((out_cnt % (TW*TH)) == (TW*TH - 1))));
        step();
        out_cnt++;
        $display("txn bp_second: data=255");

        // Reset while accumulating row 4.
        send(fill(8'd255), "rst_acc", 1'b0, '0);
        for (int i = 0; i < 4; i++) step();
        #3 rst = 1'b1;
        #1;
        chk("rst_acc_tvalid", 32'(bus.arg_0_TVALID), 32'd0);
        chk("rst_acc_tready", 32'(bus.stencil_TREADY), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_cnt = 0;
        step();
        chk("rst_acc_tready_back", 32'(bus.stencil_TREADY), 32'd1);
        chk("rst_acc_no_stale", 32'(bus.arg_0_TVALID), 32'd0);
        pixel(one_pix(4, 4, 8'd255), 8'd19, "ra_center");
        pixel(fill(8'd128), 8'd128, "ra_128");
        pixel(fill(8'd0),   8'd0,   "ra_zero");
        pixel(fill(8'd255), 8'd255, "ra_255_last");

        // Reset while an output is waiting: TVALID must drop without a clock edge.
        bus.arg_0_TREADY = 1'b0;
        send(fill(8'd200), "rst_out", 1'b0, '0);
        wait_out(lat);
        chk("rst_out_valid_up", 32'(bus.arg_0_TVALID), 32'd1);
        chk("rst_out_data", 32'(bus.arg_0_TDATA), 32'd200);
        #3 rst = 1'b1;
        #1;
        chk("rst_out_tvalid", 32'(bus.arg_0_TVALID), 32'd0);
        chk("rst_out_tdata", 32'(bus.arg_0_TDATA), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_cnt = 0;
        bus.arg_0_TREADY = 1'b1;
        step();
        pixel(one_pix(0, 0, 8'd255), 8'd0, "ro_corner");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
